// File: rtl/amostrador_entrada.sv
// Input sampler: two-flop synchroniser plus whole-word debouncer with commit strobe and glitch counter.
// Optional macro ZERO_STROBE_SUPPRESS_EN: an all-zero commit updates Entrada without pulsing Controle.
module amostrador_entrada #(
   parameter int unsigned WIDTH           = 7,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned CNT_W           = 5,
   parameter int unsigned GLITCH_W        = 8
) (
   input  logic                clk,
   input  logic                Reset,
   input  logic [WIDTH-1:0]    Bruto,
   output logic [WIDTH-1:0]    Entrada,
   output logic                Controle,
   output logic                Ocupado,
   output logic [GLITCH_W-1:0] Glitch
);

   typedef enum logic {IDLE, COUNT} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   state_t              state, state_nx;
   logic [WIDTH-1:0]    sync1, s;
   logic [WIDTH-1:0]    cand, cand_nx;
   logic [WIDTH-1:0]    entrada_nx;
   logic [CNT_W-1:0]    cnt, cnt_nx;
   logic [GLITCH_W-1:0] glitch_nx, glitch_inc;
   logic                controle_nx;

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         sync1 <= '0;
         s     <= '0;
      end else begin
         sync1 <= Bruto;
         s     <= sync1;
      end
   end

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         state    <= IDLE;
         cand     <= '0;
         cnt      <= '0;
         Entrada  <= '0;
         Glitch   <= '0;
         Controle <= 1'b0;
      end else begin
         state    <= state_nx;
         cand     <= cand_nx;
         cnt      <= cnt_nx;
         Entrada  <= entrada_nx;
         Glitch   <= glitch_nx;
         Controle <= controle_nx;
      end
   end

   // Saturating increment: holds at all-ones instead of wrapping.
   assign glitch_inc = (Glitch == '1) ? Glitch : Glitch + 1'b1;

   always_comb begin
      state_nx    = state;
      cand_nx     = cand;
      cnt_nx      = cnt;
      entrada_nx  = Entrada;
      glitch_nx   = Glitch;
      controle_nx = 1'b0;
      unique case (state)
         IDLE: begin
            if (s != Entrada) begin
               cand_nx  = s;
               cnt_nx   = CNT_W'(1);
               state_nx = COUNT;
            end
         end
         COUNT: begin
            if (s == cand) begin
               if (cnt == CNT_LAST) begin
                  entrada_nx = cand;
`ifdef ZERO_STROBE_SUPPRESS_EN
                  controle_nx = (cand != '0);
`else
                  controle_nx = 1'b1;
`endif
                  state_nx   = IDLE;
               end else begin
                  cnt_nx = cnt + 1'b1;
               end
            end else if (s == Entrada) begin
               glitch_nx = glitch_inc;
               state_nx  = IDLE;
            end else begin
               cand_nx   = s;
               cnt_nx    = CNT_W'(1);
               glitch_nx = glitch_inc;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      Ocupado = (state == COUNT);
   end

endmodule

// File: tb/tb_amostrador_entrada.sv
// Self-checking bench for amostrador_entrada: step table with scoreboard queue plus hand-timed corner sequences.
module tb_amostrador_entrada;

   logic       clk = 1'b0;
   logic       Reset;
   logic [6:0] Bruto;
   logic [6:0] Entrada;
   logic       Controle;
   logic       Ocupado;
   logic [7:0] Glitch;

   amostrador_entrada #(
      .WIDTH(7),
      .DEBOUNCE_CYCLES(16),
      .CNT_W(5),
      .GLITCH_W(8)
   ) dut (
      .clk(clk),
      .Reset(Reset),
      .Bruto(Bruto),
      .Entrada(Entrada),
      .Controle(Controle),
      .Ocupado(Ocupado),
      .Glitch(Glitch)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0] bruto;
      int         hold;
      logic [6:0] entrada;
      int         glitch;
      logic       ocupado;
      int         pulses;
   } step_t;

   step_t steps[7];
   step_t sb[$];
   step_t exp_s;

   int   checks = 0;
   int   errors = 0;
   int   pulses = 0;
   logic prev_c = 1'b0;
   int   zero_pulses;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (Controle) begin
         pulses++;
         chk("controle_spacing", int'(prev_c), 0);
      end
      prev_c = Controle;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
`ifdef ZERO_STROBE_SUPPRESS_EN
      zero_pulses = 0;
`else
      zero_pulses = 1;
`endif
      steps[0] = '{bruto: 7'h00, hold: 40, entrada: 7'h00, glitch: 0, ocupado: 1'b0, pulses: 0};
      steps[1] = '{bruto: 7'h01, hold: 30, entrada: 7'h01, glitch: 0, ocupado: 1'b0, pulses: 1};
      steps[2] = '{bruto: 7'h02, hold: 5,  entrada: 7'h01, glitch: 0, ocupado: 1'b1, pulses: 0};
      steps[3] = '{bruto: 7'h01, hold: 10, entrada: 7'h01, glitch: 1, ocupado: 1'b0, pulses: 0};
      steps[4] = '{bruto: 7'h04, hold: 8,  entrada: 7'h01, glitch: 1, ocupado: 1'b1, pulses: 0};
      steps[5] = '{bruto: 7'h08, hold: 30, entrada: 7'h08, glitch: 2, ocupado: 1'b0, pulses: 1};
      steps[6] = '{bruto: 7'h00, hold: 30, entrada: 7'h00, glitch: 2, ocupado: 1'b0, pulses: zero_pulses};

      Reset = 1'b0;
      Bruto = 7'h00;
      #12;
      chk("reset_entrada",  int'(Entrada),  0);
      chk("reset_controle", int'(Controle), 0);
      chk("reset_ocupado",  int'(Ocupado),  0);
      chk("reset_glitch",   int'(Glitch),   0);
      @(posedge clk);
      #1;
      Reset = 1'b1;

      for (int i = 0; i < 7; i++) begin
         sb.push_back(steps[i]);
         Bruto  = steps[i].bruto;
         pulses = 0;
         repeat (steps[i].hold) tick();
         exp_s = sb.pop_front();
         chk($sformatf("step%0d_entrada", i), int'(Entrada), int'(exp_s.entrada));
         chk($sformatf("step%0d_glitch", i),  int'(Glitch),  exp_s.glitch);
         chk($sformatf("step%0d_ocupado", i), int'(Ocupado), int'(exp_s.ocupado));
         chk($sformatf("step%0d_pulses", i),  pulses,        exp_s.pulses);
      end

      // Exact edge latency of a commit
      Bruto  = 7'h03;
      pulses = 0;
      for (int t = 1; t <= 19; t++) begin
         tick();
         if (t == 2) chk("lat_ocupado_e1", int'(Ocupado), 0);
         if (t == 3) chk("lat_ocupado_e2", int'(Ocupado), 1);
         if (t == 17) begin
            chk("lat_entrada_e16",  int'(Entrada),  0);
            chk("lat_controle_e16", int'(Controle), 0);
         end
         if (t == 18) begin
            chk("lat_entrada_e17",  int'(Entrada),  3);
            chk("lat_controle_e17", int'(Controle), 1);
            chk("lat_ocupado_e17",  int'(Ocupado),  0);
         end
         if (t == 19) chk("lat_controle_e18", int'(Controle), 0);
      end
      chk("lat_pulses", pulses, 1);

      // Reset asserted mid-qualification (cnt=10)
      Bruto = 7'h05;
      repeat (12) tick();
      chk("midrst_ocupado_before", int'(Ocupado), 1);
      #2;
      Reset = 1'b0;
      #1;
      chk("midrst_entrada",  int'(Entrada),  0);
      chk("midrst_glitch",   int'(Glitch),   0);
      chk("midrst_controle", int'(Controle), 0);
      chk("midrst_ocupado",  int'(Ocupado),  0);
      @(posedge clk);
      #1;
      Reset  = 1'b1;
      prev_c = 1'b0;
      pulses = 0;
      for (int t = 1; t <= 18; t++) begin
         tick();
         if (t == 17) begin
            chk("midrst_entrada_e16",  int'(Entrada),  0);
            chk("midrst_controle_e16", int'(Controle), 0);
         end
         if (t == 18) begin
            chk("midrst_entrada_e17",  int'(Entrada),  5);
            chk("midrst_controle_e17", int'(Controle), 1);
         end
      end
      chk("midrst_pulses", pulses, 1);
      chk("midrst_glitch_after", int'(Glitch), 0);

      // Bruto toggling every cycle: glitch saturates, nothing commits
      pulses = 0;
      for (int i = 0; i < 300; i++) begin
         Bruto = i[0] ? 7'h20 : 7'h10;
         tick();
      end
      chk("toggle_glitch",  int'(Glitch),  255);
      chk("toggle_pulses",  pulses,        0);
      chk("toggle_entrada", int'(Entrada), 5);
      Bruto = 7'h05;
      repeat (20) tick();
      chk("toggle_glitch_hold", int'(Glitch),  255);
      chk("toggle_ocupado_end", int'(Ocupado), 0);
      chk("toggle_pulses_end",  pulses,        0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
